lane_serializer: RTL and testbench
==================================

Name: lane_serializer

Overview:
- Parametrised successor to the fixed 16-lane byte selector.
- Captures a packed vector of LANES lanes, each W bits wide, through a load handshake.
- Emits a programmable run of lanes, one per accepted beat, on a valid/ready output stream. The run starts at a given index and wraps around modulo LANES.
- Sits between a wide datapath register bank and narrow consumers such as PE feeders and memory write ports.

Parameters:
- W, 8, width of one lane in bits.
- LANES, 16, number of lanes in the packed input; any value >= 2, power of two not required.
- SEL_W, $clog2(LANES), lane index width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load request.
- load_ready  out  1  block can accept a load (IDLE only).
- load_data  in  LANES*W  packed lanes; lane i = load_data[i*W +: W].
- start_idx  in  SEL_W  first lane to emit; sampled at load.
- count  in  SEL_W+1  number of lanes to emit; sampled at load.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  W  current lane value.
- out_idx  out  SEL_W  index of the current lane.
- out_last  out  1  current beat is the final beat of the run.
- busy  out  1  high in SEND.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (async assert of rst_n = 0):
  - State goes to IDLE; lane buffer, ptr and remaining clear to 0.
  - Reset values: out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, done=0, load_ready=1 once out of reset.
  - Reset mid-run abandons the run; no done pulse is produced.
- State IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid & load_ready: buffer <= load_data, ptr <= start_idx, remaining <= min(count, LANES).
  - If count==0: stay in IDLE and pulse done on the next cycle; no beats are emitted.
  - Otherwise go to SEND.
  - start_idx >= LANES (non-power-of-two LANES) is reduced modulo LANES at capture.
- State SEND:
  - out_valid=1, out_data=buffer[ptr], out_idx=ptr, out_last=(remaining==1), busy=1, load_ready=0.
  - On out_valid & out_ready:
    - ptr <= (ptr==LANES-1) ? 0 : ptr+1.
    - remaining <= remaining-1.
    - If remaining==1: go to IDLE and done <= 1.
  - When out_ready=0, out_data, out_idx and out_last hold stable.
  - The buffer is frozen for the whole run; load_data changes are ignored.
- Latency:
  - First beat is valid in the cycle after the load is accepted.
  - Full throughput is 1 beat per cycle with out_ready held high.
  - done is high in the cycle after the final handshake. load_ready is already 1 in that same cycle, so a new load may be accepted while done=1 (back-to-back runs, one bubble cycle).
- count > LANES is clamped to LANES: each lane is emitted at most once per run.
- Control outputs are registered; out_data is a mux of the registered buffer, selected by the registered ptr.

Optional Feature:
- Macro: LANE_SERIALIZER_REVERSE_EN.
- Defined:
  - Adds input port dir (1 bit), sampled at load alongside count.
  - dir=1 steps ptr downward: ptr <= (ptr==0) ? LANES-1 : ptr-1.
  - dir=0 behaves as the base block.
- Undefined: no dir port; ascending order only. Port list and behaviour are exactly as above.

Test Plan:
- Reset mid-run: W=8, LANES=16, load 0x0F0E..0100 with start_idx=3, count=4 → beats idx 3,4,5,6 with data 0x03,0x04,0x05,0x06; out_last only on idx 6; done one cycle after, load_ready=1; assert rst_n=0 after the 2nd beat → out_valid=0 immediately, no done, load_ready=1 after release.
- Wrap-around: start_idx=14, count=4 → idx 14,15,0,1 with data 0x0E,0x0F,0x00,0x01.
- Backpressure: out_ready toggles 1,0,0,1,… → each beat held stable while out_ready=0; the sequence is unchanged and no beat is duplicated.
- Count boundaries:
  - count=0 → no out_valid; done pulses the cycle after load.
  - count=20 → exactly 16 beats, starting at start_idx and wrapping.
- Back-to-back runs: assert load_valid with new data in the done cycle → second run's first beat appears the next cycle; a load_data change during SEND has no effect on emitted data.
- Non-power-of-two depth: LANES=5, start_idx=4, count=3 → idx 4,0,1; with LANE_SERIALIZER_REVERSE_EN and dir=1 → idx 4,3,2.

Source files
------------

// File: rtl/lane_serializer_if.sv
// lane_serializer_if: load handshake and output stream bundle for lane_serializer.
// Parameters: W (lane width), LANES (lane count); SEL_W is derived.
// Signals:
//   load_valid/load_ready, load_data, start_idx, count  - run request
//   dir (only with LANE_SERIALIZER_REVERSE_EN)          - step direction
//   out_valid/out_ready, out_data, out_idx, out_last    - beat stream
//   busy, done                                          - status
// Modports: master drives requests and out_ready; slave is the serializer.
interface lane_serializer_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 16
);
    localparam int unsigned SEL_W = $clog2(LANES);

    logic                 load_valid;
    logic                 load_ready;
    logic [LANES*W-1:0]   load_data;
    logic [SEL_W-1:0]     start_idx;
    logic [SEL_W:0]       count;
`ifdef LANE_SERIALIZER_REVERSE_EN
    logic                 dir;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [SEL_W-1:0]     out_idx;
    logic                 out_last;
    logic                 busy;
    logic                 done;

`ifdef LANE_SERIALIZER_REVERSE_EN
    modport master (
        output load_valid, load_data, start_idx, count, dir, out_ready,
        input  load_ready, out_valid, out_data, out_idx, out_last, busy, done
    );
    modport slave (
        input  load_valid, load_data, start_idx, count, dir, out_ready,
        output load_ready, out_valid, out_data, out_idx, out_last, busy, done
    );
`else
    modport master (
        output load_valid, load_data, start_idx, count, out_ready,
        input  load_ready, out_valid, out_data, out_idx, out_last, busy, done
    );
    modport slave (
        input  load_valid, load_data, start_idx, count, out_ready,
        output load_ready, out_valid, out_data, out_idx, out_last, busy, done
    );
`endif
endinterface

// File: rtl/lane_serializer.sv
// lane_serializer: captures LANES lanes of W bits and emits a run of count
// lanes starting at start_idx, wrapping modulo LANES, one per accepted beat.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - lane_serializer_if.slave (load handshake, beat stream, busy/done)
// Optional: define LANE_SERIALIZER_REVERSE_EN to add the dir input; dir=1
// walks the lanes downward.
module lane_serializer #(
    parameter int unsigned W     = 8,
    parameter int unsigned LANES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    lane_serializer_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(LANES);
    localparam int unsigned CNT_W = SEL_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       lane_q [LANES];
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               load_en;
    logic [SEL_W-1:0]   start_mod;
    logic [CNT_W-1:0]   cnt_clamp;
    logic [SEL_W-1:0]   ptr_inc;
    logic [SEL_W-1:0]   ptr_step;

    // start_idx < 2^SEL_W < 2*LANES, so one subtraction completes the modulo
    assign start_mod = (CNT_W'(bus.start_idx) >= CNT_W'(LANES))
                       ? bus.start_idx - SEL_W'(LANES) : bus.start_idx;
    // each lane is emitted at most once per run
    assign cnt_clamp = (bus.count > CNT_W'(LANES)) ? CNT_W'(LANES) : bus.count;
    assign ptr_inc   = (ptr_q == SEL_W'(LANES - 1)) ? '0 : ptr_q + SEL_W'(1);

`ifdef LANE_SERIALIZER_REVERSE_EN
    logic dir_q, dir_d;
    logic [SEL_W-1:0] ptr_dec;
    assign ptr_dec  = (ptr_q == '0) ? SEL_W'(LANES - 1) : ptr_q - SEL_W'(1);
    assign ptr_step = dir_q ? ptr_dec : ptr_inc;
`else
    assign ptr_step = ptr_inc;
`endif

    // next-state and capture control
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        last_d  = last_q;
        done_d  = 1'b0;
        load_en = 1'b0;
`ifdef LANE_SERIALIZER_REVERSE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    load_en = 1'b1;
                    ptr_d   = start_mod;
                    rem_d   = cnt_clamp;
                    last_d  = (cnt_clamp == CNT_W'(1));
`ifdef LANE_SERIALIZER_REVERSE_EN
                    dir_d   = bus.dir;
`endif
                    if (cnt_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    ptr_d  = ptr_step;
                    rem_d  = rem_q - CNT_W'(1);
                    last_d = (rem_q == CNT_W'(2));
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and lane buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LANE_SERIALIZER_REVERSE_EN
            dir_q   <= 1'b0;
`endif
            for (int i = 0; i < int'(LANES); i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef LANE_SERIALIZER_REVERSE_EN
            dir_q   <= dir_d;
`endif
            if (load_en) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    lane_q[i] <= bus.load_data[i*W +: W];
                end
            end
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.out_valid  = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.out_data   = lane_q[ptr_q];
    assign bus.out_idx    = ptr_q;
    assign bus.out_last   = last_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: randomized and directed checks of lane_serializer
// (16-lane and 5-lane instances) against a queue-based run model.
module tb_lane_serializer;
    localparam int unsigned W     = 8;
    localparam int unsigned L     = 16;
    localparam int unsigned L5    = 5;
    localparam int unsigned SEL16 = $clog2(L);
    localparam int unsigned SEL5  = $clog2(L5);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_serializer_if #(.W(W), .LANES(L))  bus16();
    lane_serializer_if #(.W(W), .LANES(L5)) bus5();

    lane_serializer #(.W(W), .LANES(L))  u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    lane_serializer #(.W(W), .LANES(L5)) u_dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: list of lane indices a run visits.
    function automatic void model_run(input int start, input int cnt, input int lanes,
                                      input bit dir, output int idxs[$]);
        int n;
        int s;
        idxs = {};
        n = (cnt > lanes) ? lanes : cnt;
        s = start % lanes;
        for (int k = 0; k < n; k++) begin
            if (dir) idxs.push_back((s - k + lanes) % lanes);
            else     idxs.push_back((s + k) % lanes);
        end
    endfunction

    function automatic logic [L*W-1:0] rand_data16();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,...
    task automatic run16(input logic [L*W-1:0] data, input int start, input int cnt,
                         input bit dir, input int ready_mode);
        int idxs[$];
        int k;
        int cyc;
        logic [L*W-1:0] sh;
        model_run(start, cnt, L, dir, idxs);
        check("load_ready_pre", bus16.load_ready, 1);
        bus16.load_valid = 1'b1;
        bus16.load_data  = data;
        bus16.start_idx  = SEL16'(start);
        bus16.count      = (SEL16+1)'(cnt);
`ifdef LANE_SERIALIZER_REVERSE_EN
        bus16.dir        = dir;
`endif
        @(posedge clk); #1;
        bus16.load_valid = 1'b0;
        bus16.load_data  = rand_data16();
        k = 0;
        cyc = 0;
        while (k < idxs.size() && cyc < 400) begin
            sh = data >> (idxs[k] * W);
            check("valid", bus16.out_valid, 1);
            check("busy", bus16.busy, 1);
            check("ld_ready_busy", bus16.load_ready, 0);
            check("idx", bus16.out_idx, idxs[k]);
            check("data", bus16.out_data, sh[W-1:0]);
            check("last", bus16.out_last, (k == idxs.size() - 1));
            check("no_done", bus16.done, 0);
            case (ready_mode)
                0:       bus16.out_ready = 1'b1;
                1:       bus16.out_ready = 1'($urandom_range(0, 1));
                default: bus16.out_ready = ((cyc % 3) == 0);
            endcase
            bus16.load_data = rand_data16();
            @(posedge clk); #1;
            if (bus16.out_ready) k++;
            cyc++;
        end
        if (cyc >= 400) check("timeout", 1, 0);
        check("done_pulse", bus16.done, 1);
        check("valid_end", bus16.out_valid, 0);
        check("ld_ready_end", bus16.load_ready, 1);
        bus16.out_ready = 1'b1;
    endtask

    task automatic idle16(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_done", bus16.done, 0);
            check("idle_valid", bus16.out_valid, 0);
        end
    endtask

    task automatic run5(input int start, input int cnt, input bit dir);
        int idxs[$];
        int k;
        int cyc;
        logic [L5*W-1:0] data;
        logic [L5*W-1:0] sh;
        data = {8'($urandom()), $urandom()};
        model_run(start, cnt, L5, dir, idxs);
        bus5.load_valid = 1'b1;
        bus5.load_data  = data;
        bus5.start_idx  = SEL5'(start);
        bus5.count      = (SEL5+1)'(cnt);
`ifdef LANE_SERIALIZER_REVERSE_EN
        bus5.dir        = dir;
`endif
        bus5.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus5.load_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < idxs.size() && cyc < 50) begin
            sh = data >> (idxs[k] * W);
            check("l5_valid", bus5.out_valid, 1);
            check("l5_idx", bus5.out_idx, idxs[k]);
            check("l5_data", bus5.out_data, sh[W-1:0]);
            check("l5_last", bus5.out_last, (k == idxs.size() - 1));
            @(posedge clk); #1;
            k++;
            cyc++;
        end
        if (cyc >= 50) check("l5_timeout", 1, 0);
        check("l5_done", bus5.done, 1);
        check("l5_valid_end", bus5.out_valid, 0);
        @(posedge clk); #1;
        check("l5_done_drop", bus5.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [L*W-1:0] ramp;
        for (int i = 0; i < int'(L); i++) ramp[i*W +: W] = W'(i);

        bus16.load_valid = 1'b0;
        bus16.load_data  = '0;
        bus16.start_idx  = '0;
        bus16.count      = '0;
        bus16.out_ready  = 1'b1;
        bus5.load_valid  = 1'b0;
        bus5.load_data   = '0;
        bus5.start_idx   = '0;
        bus5.count       = '0;
        bus5.out_ready   = 1'b1;
`ifdef LANE_SERIALIZER_REVERSE_EN
        bus16.dir = 1'b0;
        bus5.dir  = 1'b0;
`endif

        // reset values
        #1;
        check("rst_valid", bus16.out_valid, 0);
        check("rst_last", bus16.out_last, 0);
        check("rst_idx", bus16.out_idx, 0);
        check("rst_data", bus16.out_data, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_done", bus16.done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ld_ready", bus16.load_ready, 1);

        // basic run: idx 3..6
        run16(ramp, 3, 4, 1'b0, 0);
        idle16(1);

        // reset in the middle of a run
        bus16.load_valid = 1'b1;
        bus16.load_data  = ramp;
        bus16.start_idx  = SEL16'(3);
        bus16.count      = (SEL16+1)'(4);
        bus16.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus16.load_valid = 1'b0;
        check("mr_idx0", bus16.out_idx, 3);
        @(posedge clk); #1;
        check("mr_idx1", bus16.out_idx, 4);
        @(posedge clk); #1;
        check("mr_idx2", bus16.out_idx, 5);
        rst_n = 1'b0;
        #1;
        check("mr_valid", bus16.out_valid, 0);
        check("mr_busy", bus16.busy, 0);
        check("mr_done", bus16.done, 0);
        check("mr_data", bus16.out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("mr_no_done", bus16.done, 0);
            check("mr_ld_ready", bus16.load_ready, 1);
            check("mr_no_valid", bus16.out_valid, 0);
        end

        // wrap-around
        run16(ramp, 14, 4, 1'b0, 0);
        idle16(1);
        // backpressure pattern
        run16(rand_data16(), 5, 6, 1'b0, 2);
        idle16(1);
        // count = 0
        run16(ramp, 7, 0, 1'b0, 0);
        idle16(1);
        // count clamp, then back-to-back runs from the done cycle
        run16(ramp, 9, 20, 1'b0, 0);
        run16(rand_data16(), 2, 3, 1'b0, 0);
        run16(rand_data16(), 15, 16, 1'b0, 1);
        idle16(1);
`ifdef LANE_SERIALIZER_REVERSE_EN
        run16(ramp, 1, 4, 1'b1, 0);
        idle16(1);
`endif

        // randomized runs
        repeat (25) begin
            bit d;
            d = 1'b0;
`ifdef LANE_SERIALIZER_REVERSE_EN
            d = 1'($urandom_range(0, 1));
`endif
            run16(rand_data16(), int'($urandom_range(0, L - 1)), int'($urandom_range(0, 31)),
                  d, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) idle16(1);
        end

        // non-power-of-two lane count
        run5(4, 3, 1'b0);
        run5(6, 2, 1'b0);
        run5(2, 7, 1'b0);
        run5(0, 0, 1'b0);
`ifdef LANE_SERIALIZER_REVERSE_EN
        run5(4, 3, 1'b1);
        run5(1, 5, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
